mux_scan_serializer: RTL
========================

# mux_scan_serializer

Upstream sequencer for the generic 1-bit N:1 mux. It accepts an INS-bit parallel word over a valid/ready handshake and holds it on the mux data inputs. It steps the mux select from 0 to INS-1 and returns the selected bit as a serial stream with valid/ready flow control, flagging the last bit of each word. The mux itself stays external and purely combinational: this block drives `mux_w`/`mux_s` and consumes `mux_f`.

## Interface
- `INS`, default 5: word width and number of mux inputs; legal range INS >= 2. Select width SW = $clog2(INS).

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: parallel word offered.
- `in_ready` output 1: block can accept a word.
- `in_data` input INS: parallel word; bit k is emitted k-th.
- `mux_w` output INS: registered word driven to the mux `w` inputs.
- `mux_s` output SW: registered select driven to the mux `s` input.
- `mux_f` input 1: mux output, expected to equal `mux_w[mux_s]` in the same cycle.
- `out_valid` output 1: serial bit available.
- `out_ready` input 1: downstream accepts the serial bit.
- `out_bit` output 1: serial data, combinationally equal to `mux_f`.
- `out_last` output 1: current bit is bit INS-1 of the word.
- `done` output 1: registered one-cycle pulse after the last bit is accepted.

## Operation
- Two-state FSM: IDLE and SHIFT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: capture `in_data` into `mux_w`, set `mux_s`=0, go to SHIFT.
- SHIFT:
  - `in_ready`=0; `in_valid` is ignored and the word is not captured.
  - `out_valid`=1, `out_bit`=`mux_f`, `out_last`=(`mux_s`==INS-1).
- Beat = `out_valid` && `out_ready`.
  - Beat with `out_last`=0: `mux_s` increments by 1.
  - Beat with `out_last`=1: `mux_s` returns to 0, FSM goes to IDLE, `done`=1 in the next cycle.
- No beat (stall): `mux_s`, `mux_w`, `out_bit` and `out_last` hold stable. Valid is never withdrawn.
- `mux_s` never exceeds INS-1. For non-power-of-two INS (e.g. 5), wrap happens at INS-1, not at 2^SW-1.
- `mux_w` changes only on an IDLE capture. It keeps the last word after completion.
- `out_last` and `out_bit` are only meaningful while `out_valid`=1. `out_last` is driven 0 in IDLE.
- Reset, asynchronous, any time including mid-word:
  - FSM goes to IDLE; `mux_w`=0, `mux_s`=0, `done`=0.
  - Hence `out_valid`=0, `out_last`=0, `in_ready`=1 immediately.
  - The partial word is discarded; no `done` is produced for it.

## Timing
- Load accepted at edge t: first bit (bit 0) is valid in cycle t+1.
- With `out_ready` held at 1, bit k is presented in cycle t+1+k; the last beat is at cycle t+INS.
- `done` is high in cycle t+INS+1, the same cycle the FSM is back in IDLE with `in_ready`=1.
- Throughput: one word per INS+1 cycles with one IDLE bubble between words. There is no overlap of load and shift.
- Each `out_ready` low cycle extends the word by exactly one cycle.
- `in_ready` depends only on state, not on `in_valid`. `out_valid` depends only on state, not on `out_ready`. There are no combinational ready/valid loops.
- `out_bit` has a combinational path from `mux_f`. The mux delay plus the downstream logic must close within one cycle.

## Test plan
- Reset then idle: outputs `in_ready`=1, `out_valid`=0, `mux_s`=0, `mux_w`=0, `done`=0.
- INS=5, load 5'b10110, `out_ready`=1: `out_bit` sequence 0,1,1,0,1 in cycles t+1..t+5. `out_last` is high only at t+5, `done` pulses at t+6, `mux_s` goes 0,1,2,3,4,0.
- Same word with `out_ready` low at the bit-2 cycle for 3 cycles: `mux_s`=2 and `out_bit`=1 hold for 4 cycles. The stream is otherwise unchanged and `done` is delayed by 3 cycles.
- `in_valid` held high with a new word (5'b01001) during SHIFT: it is not captured and `mux_w` stays 5'b10110. It is accepted in the IDLE cycle after `done`, and its stream is 1,0,0,1,0.
- Assert `reset` asynchronously at the bit-3 cycle: `out_valid` drops before the next edge, there is no `done`, and the next load restarts from bit 0.
- INS=2 and INS=8: `mux_s` wraps at 1 and at 7 respectively. Check the scoreboard relation `out_bit`==`in_data`[k] for 100 random words with random `out_ready`.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - parallel word to serial bit stream sequencer driving an external N:1 mux
module mux_scan_serializer #(
    parameter int INS = 5,
    localparam int SW = $clog2(INS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [INS-1:0]  in_data,
    output logic [INS-1:0]  mux_w,
    output logic [SW-1:0]   mux_s,
    input  logic            mux_f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic            done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Wrap point is INS-1, not the natural 2^SW-1 rollover of the select.
    localparam logic [SW-1:0] LAST_SEL = SW'(INS - 1);

    state_t state;
    state_t state_nxt;
    logic   is_last;
    logic   beat;
    logic   load;

    assign is_last = (mux_s == LAST_SEL);
    assign beat    = out_valid && out_ready;
    assign load    = (state == IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load leaves IDLE, the accepted last bit returns to it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (out_ready && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so no ready/valid loops form
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == SHIFT);
        out_last  = (state == SHIFT) && is_last;
        out_bit   = mux_f;
    end

    // Word/select datapath and the completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_w <= '0;
            mux_s <= '0;
            done  <= 1'b0;
        end else begin
            done <= beat && is_last;
            if (load) begin
                mux_w <= in_data;
                mux_s <= '0;
            end else if (beat) begin
                mux_s <= is_last ? '0 : mux_s + SW'(1);
            end
        end
    end

endmodule
